// File: rtl/scratch_stack_ram.sv
// Scratch RAM with an asynchronous read port and a downward-growing hardware stack.
// Define SCR_STACK_FLAGS_EN to add the occupancy counter and the sticky OVF/UNF flags.
module scratch_stack_ram #(
    parameter int          DATA_W  = 10,
    parameter int          ADDR_W  = 8,
    parameter int unsigned SP_INIT = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] SCR_DIN,
    input  logic [ADDR_W-1:0] SCR_ADDR,
    input  logic              SCR_WE,
    input  logic              SP_LD,
    input  logic [ADDR_W-1:0] SP_DIN,
    input  logic              SP_PUSH,
    input  logic              SP_POP,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic [ADDR_W-1:0] SP_OUT,
    output logic              OVF,
    output logic              UNF
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic              push_v, pop_v, push_ok, pop_ok;

    // Simultaneous push and pop cancel each other; only SCR_WE remains.
    assign push_v = SP_PUSH & ~SP_POP;
    assign pop_v  = SP_POP & ~SP_PUSH;

`ifdef SCR_STACK_FLAGS_EN
    localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W:0] cnt_q, cnt_d;
    logic            ovf_q, ovf_d, unf_q, unf_d;

    assign push_ok = push_v & (cnt_q != CNT_FULL);
    assign pop_ok  = pop_v & (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (SP_LD) begin
            cnt_d = '0;
        end else if (push_v) begin
            if (push_ok) cnt_d = cnt_q + 1'b1;
            else         ovf_d = 1'b1;
        end else if (pop_v) begin
            if (pop_ok) cnt_d = cnt_q - 1'b1;
            else        unf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign OVF = ovf_q;
    assign UNF = unf_q;
`else
    assign push_ok = push_v;
    assign pop_ok  = pop_v;
    assign OVF     = 1'b0;
    assign UNF     = 1'b0;
`endif

    // A push request owns the write port even when it is suppressed as an overflow.
    always_comb begin
        sp_d    = sp_q;
        wr_req  = 1'b0;
        wr_addr = SCR_ADDR;
        if (SP_LD) begin
            sp_d   = SP_DIN;
            wr_req = SCR_WE;
        end else if (push_v) begin
            if (push_ok) begin
                sp_d    = sp_q - ADDR_W'(1);
                wr_req  = 1'b1;
                wr_addr = sp_q - ADDR_W'(1);
            end
        end else if (pop_v) begin
            if (pop_ok) sp_d = sp_q + ADDR_W'(1);
            wr_req = SCR_WE;
        end else begin
            wr_req = SCR_WE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sp_q <= ADDR_W'(SP_INIT);
        end else begin
            sp_q <= sp_d;
            if (wr_req) mem_q[wr_addr] <= SCR_DIN;
        end
    end

    assign DATA_OUT = SP_POP ? mem_q[sp_q] : mem_q[SCR_ADDR];
    assign SP_OUT   = sp_q;
endmodule

// File: tb/tb_scratch_stack_ram.sv
// Randomised and directed bench for scratch_stack_ram against an array-based stack model.
module tb_scratch_stack_ram;
  localparam int DW = 10;
  localparam int AW = 8;
  localparam int DEPTH = 256;
  localparam int SP0 = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0] scr_din = '0;
  logic [AW-1:0] scr_addr = '0;
  logic scr_we = 1'b0;
  logic sp_ld = 1'b0;
  logic [AW-1:0] sp_din = '0;
  logic sp_push = 1'b0;
  logic sp_pop = 1'b0;
  logic [DW-1:0] data_out;
  logic [AW-1:0] sp_out;
  logic ovf, unf;

  int n_total = 0;
  int n_bad = 0;

  // reference model
  logic [DW-1:0] m_mem [DEPTH];
  int m_sp, m_cnt;
  bit m_ovf, m_unf;
`ifdef SCR_STACK_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  scratch_stack_ram #(.DATA_W(DW), .ADDR_W(AW), .SP_INIT(SP0)) dut (
    .CLK(clk), .RST(rst), .SCR_DIN(scr_din), .SCR_ADDR(scr_addr), .SCR_WE(scr_we),
    .SP_LD(sp_ld), .SP_DIN(sp_din), .SP_PUSH(sp_push), .SP_POP(sp_pop),
    .DATA_OUT(data_out), .SP_OUT(sp_out), .OVF(ovf), .UNF(unf)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_read();
    return sp_pop ? m_mem[m_sp] : m_mem[int'(scr_addr)];
  endfunction

  // Behaviour of one rising edge, straight from the stack rules.
  task automatic model_edge();
    if (rst) begin
      m_sp = SP0; m_cnt = 0; m_ovf = 0; m_unf = 0;
    end else if (sp_ld) begin
      if (scr_we) m_mem[int'(scr_addr)] = scr_din;
      m_sp = int'(sp_din);
      m_cnt = 0;
    end else if (sp_push && !sp_pop) begin
      if (FLAGS && m_cnt == DEPTH) m_ovf = 1;
      else begin
        m_sp = (m_sp + DEPTH - 1) % DEPTH;
        m_mem[m_sp] = scr_din;
        m_cnt++;
      end
    end else if (sp_pop && !sp_push) begin
      if (FLAGS && m_cnt == 0) m_unf = 1;
      else begin
        m_sp = (m_sp + 1) % DEPTH;
        m_cnt--;
      end
      if (scr_we) m_mem[int'(scr_addr)] = scr_din;
    end else if (scr_we) begin
      m_mem[int'(scr_addr)] = scr_din;
    end
  endtask

  // driver tasks
  task automatic idle();
    rst = 0; scr_we = 0; sp_ld = 0; sp_push = 0; sp_pop = 0;
  endtask

  task automatic step();
    #1;
    check("data_out", 32'(data_out), 32'(model_read()));
    @(posedge clk);
    model_edge();
    #1;
    check("sp_out", 32'(sp_out), 32'(m_sp));
    check("ovf", 32'(ovf), 32'(m_ovf));
    check("unf", 32'(unf), 32'(m_unf));
  endtask

  task automatic do_reset();
    idle(); rst = 1; step(); rst = 0;
  endtask

  task automatic push(input logic [DW-1:0] d);
    idle(); sp_push = 1; scr_din = d; step();
  endtask

  task automatic read_addr(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    idle(); scr_addr = a; #1;
    check(tag, 32'(data_out), 32'(exp));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_sp = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;

    do_reset();
    do_reset();
    check("rst_sp", 32'(sp_out), SP0);
    check("rst_flags", 32'({ovf, unf}), 0);
    read_addr(8'h33, '0, "mem_zero");

    // push one word, then pop it back
    push(10'h155);
    check("push_sp", 32'(sp_out), 255);
    read_addr(8'hFF, 10'h155, "push_mem");
    idle(); sp_pop = 1; #1;
    check("pop_data", 32'(data_out), 32'h155);
    step();
    check("pop_sp", 32'(sp_out), 0);

    // direct write then same-cycle read
    idle(); scr_we = 1; scr_addr = 8'h10; scr_din = 10'h2AA; step();
    read_addr(8'h10, 10'h2AA, "direct_rd");

    // push+pop together with a direct write
    idle(); sp_push = 1; sp_pop = 1; scr_we = 1; scr_addr = 8'h20; scr_din = 10'h0C3; step();
    check("pp_sp", 32'(sp_out), 0);
    read_addr(8'h20, 10'h0C3, "pp_we");

    // load wins over push
    idle(); sp_ld = 1; sp_push = 1; sp_din = 8'h80; scr_din = 10'h3E1; step();
    check("ld_sp", 32'(sp_out), 8'h80);
    read_addr(8'h7F, '0, "ld_nopush");

    // push owns the write port over a direct write
    idle(); sp_push = 1; scr_we = 1; scr_addr = 8'h40; scr_din = 10'h111; step();
    read_addr(8'h7F, 10'h111, "pushwe_mem");
    read_addr(8'h40, '0, "pushwe_drop");

    // empty pop and full push
    do_reset();
    idle(); sp_pop = 1; step();
`ifdef SCR_STACK_FLAGS_EN
    check("unf_sp", 32'(sp_out), 0);
    check("unf_flag", 32'(unf), 1);
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(DW'(i + 5));
    check("full_sp", 32'(sp_out), 0);
    check("full_ovf0", 32'(ovf), 0);
    push(10'h3FF);
    check("ovf_flag", 32'(ovf), 1);
    check("ovf_sp", 32'(sp_out), 0);
    read_addr(8'hFF, 10'h005, "ovf_mem");
`else
    check("wrap_sp", 32'(sp_out), 1);
    check("wrap_unf", 32'(unf), 0);
`endif

    // reset cancels a push and keeps memory
    do_reset();
    push(10'h0A1); push(10'h0A2); push(10'h0A3);
    idle(); rst = 1; sp_push = 1; scr_din = 10'h2F0; step();
    check("rstp_sp", 32'(sp_out), SP0);
    check("rstp_flags", 32'({ovf, unf}), 0);
    read_addr(8'hFF, 10'h0A1, "rstp_w0");
    read_addr(8'hFE, 10'h0A2, "rstp_w1");
    read_addr(8'hFD, 10'h0A3, "rstp_w2");
    read_addr(8'hFC, m_mem[252], "rstp_w3");

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      sp_ld = ($urandom_range(0, 29) == 0);
      sp_push = ($urandom_range(0, 2) != 0);
      sp_pop = ($urandom_range(0, 2) == 0);
      scr_we = ($urandom_range(0, 1) == 1);
      scr_addr = AW'($urandom_range(0, DEPTH - 1));
      sp_din = AW'($urandom_range(0, DEPTH - 1));
      scr_din = DW'($urandom);
      step();
    end

    // full memory readback
    for (int a = 0; a < DEPTH; a++) read_addr(AW'(a), m_mem[a], "final_mem");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/scratch_stack_ram.md
SCRATCH_STACK_RAM -- requirements
Module: scratch_stack_ram

Interface
REQ-001 Parameter DATA_W, default 10, SHALL set the word width.
REQ-002 Parameter ADDR_W, default 8, SHALL set the address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter SP_INIT, default 0, SHALL set the stack-pointer value loaded on reset.
REQ-004 CLK  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 RST  in  1  SHALL be the reset: synchronous, active-high.
REQ-006 SCR_DIN  in  DATA_W  SHALL carry write data for both direct writes and pushes.
REQ-007 SCR_ADDR  in  ADDR_W  SHALL carry the direct read/write address.
REQ-008 SCR_WE  in  1  SHALL request a direct write of SCR_DIN to SCR_ADDR.
REQ-009 SP_LD  in  1  SHALL request a load of SP_DIN into the stack pointer.
REQ-010 SP_DIN  in  ADDR_W  SHALL carry the stack-pointer load value.
REQ-011 SP_PUSH  in  1  SHALL request a push of SCR_DIN.
REQ-012 SP_POP  in  1  SHALL request a pop.
REQ-013 DATA_OUT  out  DATA_W  SHALL carry the combinational read data.
REQ-014 SP_OUT  out  ADDR_W  SHALL carry the current stack pointer.
REQ-015 OVF, UNF  out  1 each  SHALL carry the sticky overflow and underflow flags.

Function
REQ-016 Memory SHALL be DEPTH x DATA_W, with every word zero at configuration; reads SHALL be asynchronous and writes synchronous.
REQ-017 DATA_OUT SHALL equal mem[SP] while SP_POP=1, and mem[SCR_ADDR] otherwise, with no clock latency.
REQ-018 The stack SHALL grow downward: a push SHALL write SCR_DIN to mem[SP-1] and set SP <= SP-1, both in the same edge.
REQ-019 A pop SHALL set SP <= SP+1; the popped word SHALL be the DATA_OUT value during the pop cycle.
REQ-020 Pointer arithmetic SHALL be modulo DEPTH (ADDR_W bits, wrap-around).
REQ-021 Per-edge priority SHALL be RST > SP_LD > (SP_PUSH xor SP_POP) > SCR_WE for the pointer and the write port.
REQ-022 When SP_PUSH and SP_POP are both 1, the block SHALL leave SP and memory unchanged and SHALL still honour SCR_WE.
REQ-023 A valid push SHALL own the write port; a concurrent SCR_WE SHALL be dropped.
REQ-024 SP_LD SHALL load SP only; concurrent SCR_WE SHALL still write, and a concurrent push/pop SHALL be ignored.
REQ-025 SCR_WE with no push SHALL write SCR_DIN to mem[SCR_ADDR] (same behaviour as the current scratch RAM).

Reset
REQ-026 On a rising edge with RST=1: SP_OUT <= SP_INIT, OVF <= 0, UNF <= 0, and the occupancy counter (if present) <= 0.
REQ-027 Reset SHALL NOT alter memory contents, and SHALL block every write in the same cycle.
REQ-028 A reset during a push or pop SHALL cancel that operation completely.

Configuration
REQ-029 Macro SCR_STACK_FLAGS_EN defined: the block SHALL include an occupancy counter of ADDR_W+1 bits, with the following behaviour:
- a valid push increments the counter and a valid pop decrements it;
- SP_LD clears the counter to 0;
- a push at occupancy DEPTH is suppressed (no write, no SP change) and sets OVF;
- a pop at occupancy 0 is suppressed (SP unchanged) and sets UNF;
- OVF and UNF stay set until RST.
REQ-030 Macro SCR_STACK_FLAGS_EN undefined: the block SHALL have no counter, SP SHALL wrap freely, no push or pop SHALL be suppressed, and OVF and UNF SHALL be tied to 0.

Verification
REQ-031 Reset with SP_INIT=0, then push 0x155 -> mem[255]=0x155, SP_OUT=255; assert SP_POP -> DATA_OUT=0x155 before the edge, SP_OUT=0 after it.
REQ-032 SCR_WE=1, SCR_ADDR=0x10, SCR_DIN=0x2AA, then read 0x10 -> DATA_OUT=0x2AA in the same cycle as the address is applied, with no clock edge.
REQ-033 SP_PUSH=SP_POP=1 with SCR_WE=1 to 0x20 -> SP unchanged, mem[0x20]=SCR_DIN; SP_LD=1 with SP_PUSH=1, SP_DIN=0x80 -> SP_OUT=0x80, no push write.
REQ-034 With the macro defined: pop after reset -> UNF=1, SP_OUT=0; 256 pushes then a 257th -> OVF=1, SP_OUT=0, mem[255] unchanged by the 257th push. Without the macro: the same pop -> SP_OUT=1, UNF=0.
REQ-035 RST=1 asserted together with SP_PUSH=1 after pushing 3 words -> SP_OUT=SP_INIT, flags 0, the three previously pushed words still readable via SCR_ADDR.
